// File: rtl/operand_fetch_ctrl.sv
// Streams COUNT operand pairs from two combinational operand memories to a valid/ready consumer.
// Latency: start sampled -> out_valid two edges later; done pulses one edge after the DONE state.
// Backpressure: a presented pair is held stable until out_ready; no timeout.
module operand_fetch_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base1_addr,
    input  logic [ADDR_W-1:0] base2_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] operand1_addr,
    input  logic [DATA_W-1:0] operand1_value,
    output logic [ADDR_W-1:0] operand2_addr,
    input  logic [DATA_W-1:0] operand2_value,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr1_q <= '0;
            addr2_q <= '0;
            rem_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            rem_q   <= rem_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        rem_d   = rem_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The done pulse lands in an IDLE cycle; a start there belongs to the finished run.
                if (start && !done_q) begin
                    addr1_d = base1_addr;
                    addr2_d = base2_addr;
                    rem_d   = count;
                    state_d = (count == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                op1_d   = operand1_value;
                op2_d   = operand2_value;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (valid_q && out_ready) begin
                    rem_d   = rem_q - (ADDR_W+1)'(1);
                    valid_d = 1'b0;
                    if (rem_q == (ADDR_W+1)'(1)) begin
                        state_d = DONE;
                    end else begin
                        addr1_d = addr1_q + ADDR_W'(1);
                        addr2_d = addr2_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign operand1_addr = addr1_q;
    assign operand2_addr = addr2_q;
    assign out_op1       = op1_q;
    assign out_op2       = op2_q;
    assign out_valid     = valid_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed and randomized runs of operand_fetch_ctrl against a queue-based model of expected pairs.
module tb_operand_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base1_addr = '0;
    logic [3:0]  base2_addr = '0;
    logic [4:0]  count = '0;
    logic [3:0]  operand1_addr, operand2_addr;
    logic [15:0] operand1_value, operand2_value;
    logic [15:0] out_op1, out_op2;
    logic        out_valid, busy, done;
    logic        out_ready = 1'b0;

    logic [15:0] mem1 [16];
    logic [15:0] mem2 [16];

    int n_chk = 0;
    int n_fail = 0;

    operand_fetch_ctrl #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base1_addr(base1_addr), .base2_addr(base2_addr), .count(count),
        .operand1_addr(operand1_addr), .operand1_value(operand1_value),
        .operand2_addr(operand2_addr), .operand2_value(operand2_value),
        .out_op1(out_op1), .out_op2(out_op2), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    assign operand1_value = mem1[operand1_addr];
    assign operand2_value = mem2[operand2_addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then return at the following falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one complete run; expected pairs are taken from the memory contents at start.
    task automatic run(input int b1, input int b2, input int cnt, input int max_stall,
                       input int fixed_pair, input int fixed_len, input bit poke_start);
        logic [15:0] e1 [$];
        logic [15:0] e2 [$];
        int          a1 [$];
        int          a2 [$];
        int          stall;
        for (int i = 0; i < cnt; i++) begin
            a1.push_back((b1 + i) % 16);
            a2.push_back((b2 + i) % 16);
            e1.push_back(mem1[(b1 + i) % 16]);
            e2.push_back(mem2[(b2 + i) % 16]);
        end
        start      = 1'b1;
        base1_addr = 4'(b1);
        base2_addr = 4'(b2);
        count      = 5'(cnt);
        tick();
        start      = 1'b0;
        base1_addr = 4'($urandom);
        base2_addr = 4'($urandom);
        count      = 5'($urandom_range(1, 16));
        if (cnt == 0) begin
            chk("zero_busy", busy, 1);
            chk("zero_valid", out_valid, 0);
            chk("zero_done_early", done, 0);
            tick();
            chk("zero_done", done, 1);
            chk("zero_busy_done", busy, 0);
            chk("zero_valid2", out_valid, 0);
            tick();
            chk("zero_done_drop", done, 0);
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            chk("fetch_valid_low", out_valid, 0);
            chk("fetch_busy", busy, 1);
            if (poke_start) begin
                start = 1'b1;
                base1_addr = 4'($urandom);
                base2_addr = 4'($urandom);
            end
            tick();
            start = 1'b0;
            chk("pair_valid", out_valid, 1);
            chk("pair_op1", out_op1, e1[i]);
            chk("pair_op2", out_op2, e2[i]);
            chk("pair_addr1", operand1_addr, a1[i]);
            chk("pair_addr2", operand2_addr, a2[i]);
            stall = (i == fixed_pair) ? fixed_len : $urandom_range(0, max_stall);
            for (int s = 0; s < stall; s++) begin
                out_ready = 1'b0;
                mem1[a1[i]] = 16'($urandom);
                mem2[a2[i]] = 16'($urandom);
                start = poke_start;
                tick();
                start = 1'b0;
                chk("hold_valid", out_valid, 1);
                chk("hold_op1", out_op1, e1[i]);
                chk("hold_op2", out_op2, e2[i]);
                chk("hold_addr1", operand1_addr, a1[i]);
                chk("hold_addr2", operand2_addr, a2[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'($urandom);
            chk("done_idle_low", done, 0);
        end
        chk("last_valid_low", out_valid, 0);
        chk("last_busy", busy, 1);
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy_low", busy, 0);
        chk("done_valid_low", out_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_drop", done, 0);
        chk("start_in_done_ignored", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 16'($urandom);
            mem2[i] = 16'($urandom);
        end
        mem1[0] = 16'h4DA3;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr1", operand1_addr, 0);
        chk("rst_op1", out_op1, 0);
        rst_n = 1'b1;
        tick();

        // Reset while a pair is presented
        start = 1'b1; base1_addr = 4'd2; base2_addr = 4'd5; count = 5'd3;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr1", operand1_addr, 0);
        chk("mid_rst_addr2", operand2_addr, 0);
        chk("mid_rst_op1", out_op1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_no_done", done, 0);
            chk("post_rst_idle", busy, 0);
        end

        run(0, 0, 1, 0, -1, 0, 1'b0);
        run(14, 3, 4, 0, -1, 0, 1'b0);
        run(7, 9, 3, 0, 1, 5, 1'b0);
        run(5, 5, 0, 0, -1, 0, 1'b0);
        run(10, 1, 2, 2, -1, 0, 1'b1);
        run(0, 8, 16, 1, -1, 0, 1'b0);
        for (int r = 0; r < 20; r++) begin
            run($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 16),
                3, -1, 0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
